// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter in front of the SDRAM controller slave.
// Port 0 has fixed priority, port 1 is protected by a starvation counter, read data is routed by tag.
module sdram_port_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int MAX_STARVE  = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s0_address,
    input  logic                s0_read,
    input  logic                s0_write,
    input  logic [DATA_W-1:0]   s0_writedata,
    input  logic [DATA_W/8-1:0] s0_byteenable,
    output logic                s0_waitrequest,
    output logic [DATA_W-1:0]   s0_readdata,
    output logic                s0_readdatavalid,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W-1:0]   s1_writedata,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    output logic                s1_waitrequest,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                err_orphan
);
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PENDING);
    localparam logic [7:0]       STARVE_MAX = 8'(MAX_STARVE);

    logic [1:0] rd, wr, req, elig, grant, accept, rdv;

    logic                   lock_reg;
    logic                   lock_port_reg;
    logic [7:0]             starve_reg;
    logic [CNT_W-1:0]       pending_reg;
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [MAX_PENDING-1:0] tag_reg;
    logic                   err_reg;

    logic fifo_empty, pop, push, head, read_room, sel;

    assign rd = {s1_read, s0_read};
    assign wr = {s1_write, s0_write};

    assign fifo_empty = (pending_reg == '0);
    assign pop        = m_readdatavalid & ~fifo_empty & ~reset;
    assign head       = tag_reg[rd_ptr_reg];
    // A return in this same cycle frees a slot, so a read may be accepted into a full FIFO.
    assign read_room  = (pending_reg < PEND_MAX) | pop;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req[gi]    = rd[gi] | wr[gi];
            assign elig[gi]   = req[gi] & (~rd[gi] | read_room);
            assign accept[gi] = grant[gi] & ~m_waitrequest;
            assign rdv[gi]    = pop & (head == 1'(gi));
        end
    endgenerate

    always_comb begin
        grant = 2'b00;
        if (reset)
            grant = 2'b00;
        else if (lock_reg)
            grant = lock_port_reg ? 2'b10 : 2'b01;
        else if ((starve_reg == STARVE_MAX) && elig[1])
            grant = 2'b10;
        else if (elig[0])
            grant = 2'b01;
        else if (elig[1])
            grant = 2'b10;
    end

    assign sel  = grant[1];
    assign push = |(accept & rd);

    assign m_address    = sel ? s1_address    : s0_address;
    assign m_writedata  = sel ? s1_writedata  : s0_writedata;
    assign m_byteenable = sel ? s1_byteenable : s0_byteenable;
    assign m_read       = |(grant & rd);
    assign m_write      = |(grant & wr & ~rd);

    assign s0_waitrequest   = ~grant[0] | m_waitrequest;
    assign s1_waitrequest   = ~grant[1] | m_waitrequest;
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = rdv[0];
    assign s1_readdatavalid = rdv[1];
    assign err_orphan       = err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_reg      <= 1'b0;
            lock_port_reg <= 1'b0;
            starve_reg    <= '0;
            pending_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            tag_reg       <= '0;
            err_reg       <= 1'b0;
        end else begin
            // A stalled grant must be held until the slave takes it.
            lock_reg      <= (|grant) & m_waitrequest;
            lock_port_reg <= sel;

            if (~req[1] | accept[1])
                starve_reg <= '0;
            else if (starve_reg < STARVE_MAX)
                starve_reg <= starve_reg + 8'd1;

            if (push) begin
                tag_reg[wr_ptr_reg] <= sel;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);

            if (push & ~pop)
                pending_reg <= pending_reg + CNT_W'(1);
            else if (pop & ~push)
                pending_reg <= pending_reg - CNT_W'(1);

            if (m_readdatavalid & fifo_empty)
                err_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations at the points of interest in each scenario.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 24, DATA_W = 16, MAX_STARVE = 8, MAX_PENDING = 4;

    logic clock = 1'b0;
    logic reset;
    logic [ADDR_W-1:0] s0_address, s1_address, m_address;
    logic s0_read, s0_write, s1_read, s1_write;
    logic [DATA_W-1:0] s0_writedata, s1_writedata, m_writedata;
    logic [DATA_W/8-1:0] s0_byteenable, s1_byteenable, m_byteenable;
    logic s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [DATA_W-1:0] s0_readdata, s1_readdata, m_readdata;
    logic m_read, m_write, m_waitrequest, m_readdatavalid, err_orphan;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(MAX_STARVE), .MAX_PENDING(MAX_PENDING)
    ) dut (
        .clock(clock), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .err_orphan(err_orphan)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding reads as a queue of port IDs, lock owner, starvation count.
    int lock_port = -1;
    int starve = 0;
    int q[$];
    bit orphan = 0;

    always @(negedge clock) begin : model
        int g;
        bit room, e0, e1, rd_g, wr_g, acc, vld, req1;
        room = (q.size() < MAX_PENDING) || (m_readdatavalid && q.size() > 0);
        e0 = (s0_read || s0_write) && (!s0_read || room);
        e1 = (s1_read || s1_write) && (!s1_read || room);
        g = -1;
        if (reset) g = -1;
        else if (lock_port >= 0) g = lock_port;
        else if (starve == MAX_STARVE && e1) g = 1;
        else if (e0) g = 0;
        else if (e1) g = 1;
        rd_g = (g == 0) ? s0_read  : (g == 1) ? s1_read  : 1'b0;
        wr_g = (g == 0) ? s0_write : (g == 1) ? s1_write : 1'b0;

        check("m_read", m_read, rd_g);
        check("m_write", m_write, wr_g && !rd_g);
        check("s0_waitrequest", s0_waitrequest, (g != 0) || m_waitrequest);
        check("s1_waitrequest", s1_waitrequest, (g != 1) || m_waitrequest);
        if (rd_g || wr_g)
            check("m_address", m_address, (g == 0) ? s0_address : s1_address);
        if (wr_g && !rd_g) begin
            check("m_writedata", m_writedata, (g == 0) ? s0_writedata : s1_writedata);
            check("m_byteenable", m_byteenable, (g == 0) ? s0_byteenable : s1_byteenable);
        end
        vld = !reset && m_readdatavalid && q.size() > 0;
        check("s0_readdatavalid", s0_readdatavalid, vld && q[0] == 0);
        check("s1_readdatavalid", s1_readdatavalid, vld && q[0] == 1);
        if (vld)
            check("readdata", (q[0] == 0) ? s0_readdata : s1_readdata, m_readdata);
        check("err_orphan", err_orphan, orphan);

        if (reset) begin
            lock_port = -1;
            starve = 0;
            q.delete();
            orphan = 0;
        end else begin
            acc = (g >= 0) && !m_waitrequest;
            if (m_readdatavalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else orphan = 1;
            end
            if (acc && rd_g) q.push_back(g);
            lock_port = ((g >= 0) && m_waitrequest) ? g : -1;
            req1 = s1_read || s1_write;
            if (!req1 || (acc && g == 1)) starve = 0;
            else if (starve < MAX_STARVE) starve++;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
        m_waitrequest = 0; m_readdatavalid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ip[5];
        ip = '{0, 1, 1, 0, 0};
        reset = 1;
        s0_address = '0; s1_address = '0; s0_writedata = '0; s1_writedata = '0;
        s0_byteenable = 2'b11; s1_byteenable = 2'b01; m_readdata = '0;
        idle();

        // Reset holds the command path off even with a request present
        cyc(); cyc();
        s0_read = 1; s0_address = 24'h000100;
        #1;
        check("rst_m_read", m_read, 0);
        check("rst_wait0", s0_waitrequest, 1);
        check("rst_wait1", s1_waitrequest, 1);
        cyc(); reset = 0; s0_read = 0;
        #1 check("rst_err", err_orphan, 0);

        // Single read on port 0, data three cycles later
        cyc(); s0_read = 1; s0_address = 24'h000100;
        #1;
        check("p0_m_read", m_read, 1);
        check("p0_m_addr", m_address, 24'h000100);
        check("p0_wait", s0_waitrequest, 0);
        cyc(); idle(); cyc(); cyc();
        m_readdatavalid = 1; m_readdata = 16'hA5A5;
        #1;
        check("p0_rdv0", s0_readdatavalid, 1);
        check("p0_rdata", s0_readdata, 16'hA5A5);
        check("p0_rdv1", s1_readdatavalid, 0);
        cyc(); idle();

        // Single read on port 1
        cyc(); s1_read = 1; s1_address = 24'h000200;
        #1;
        check("p1_m_addr", m_address, 24'h000200);
        check("p1_wait", s1_waitrequest, 0);
        cyc(); idle(); cyc(); cyc();
        m_readdatavalid = 1; m_readdata = 16'h5A5A;
        #1;
        check("p1_rdv1", s1_readdatavalid, 1);
        check("p1_rdata", s1_readdata, 16'h5A5A);
        check("p1_rdv0", s0_readdatavalid, 0);
        cyc(); idle();

        // Continuous writes on both ports: port 1 wins on the 9th and 18th cycles
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (k == 0) begin
                s0_write = 1; s0_address = 24'h10; s0_writedata = 16'hAAAA;
                s1_write = 1; s1_address = 24'h20; s1_writedata = 16'hBBBB;
            end
            #1;
            check($sformatf("starve_wait1_%0d", k), s1_waitrequest, (k == 8 || k == 17) ? 0 : 1);
            check($sformatf("starve_addr_%0d", k), m_address, (k == 8 || k == 17) ? 24'h20 : 24'h10);
        end
        cyc(); idle();

        // Lock: port 1 stalled five cycles, port 0 waits behind it
        cyc(); s1_write = 1; s1_address = 24'h222; s1_writedata = 16'h1111; m_waitrequest = 1;
        #1;
        check("lock_m_write", m_write, 1);
        check("lock_wait1", s1_waitrequest, 1);
        for (int k = 1; k < 5; k++) begin
            cyc(); s0_write = 1; s0_address = 24'h333; s0_writedata = 16'h3333;
            #1;
            check($sformatf("lock_addr_%0d", k), m_address, 24'h222);
            check($sformatf("lock_wdata_%0d", k), m_writedata, 16'h1111);
            check($sformatf("lock_wait0_%0d", k), s0_waitrequest, 1);
        end
        cyc(); m_waitrequest = 0;
        #1;
        check("lock_acc1", s1_waitrequest, 0);
        check("lock_hold0", s0_waitrequest, 1);
        cyc(); s1_write = 0;
        #1;
        check("lock_acc0", s0_waitrequest, 0);
        check("lock_addr0", m_address, 24'h333);
        cyc(); idle();

        // Pending limit: 4 reads fill the tag FIFO
        for (int k = 0; k < 4; k++) begin
            cyc(); s0_read = 1; s0_address = 24'h400 + 24'(k);
            #1 check($sformatf("pend_acc_%0d", k), s0_waitrequest, 0);
        end
        cyc(); s0_address = 24'h404; s1_write = 1; s1_address = 24'h500; s1_writedata = 16'h5555;
        #1;
        check("pend_stall0", s0_waitrequest, 1);
        check("pend_w1", s1_waitrequest, 0);
        check("pend_m_write", m_write, 1);
        cyc(); s1_write = 0; m_readdatavalid = 1; m_readdata = 16'h0001;
        #1;
        check("pend_rdv0", s0_readdatavalid, 1);
        check("pend_acc5", s0_waitrequest, 0);
        check("pend_addr5", m_address, 24'h404);
        for (int k = 0; k < 4; k++) begin
            cyc(); s0_read = 0; m_readdatavalid = 1; m_readdata = 16'h0002 + 16'(k);
            #1 check($sformatf("pend_drain_%0d", k), s0_readdatavalid, 1);
        end
        cyc(); idle();

        // Interleaved pipelined reads p0,p1,p1,p0 then p0 with a same-cycle return
        for (int k = 0; k < 9; k++) begin
            cyc(); idle();
            if (k < 5) begin
                if (ip[k] == 0) begin s0_read = 1; s0_address = 24'h600 + 24'(k); end
                else begin s1_read = 1; s1_address = 24'h700 + 24'(k); end
            end
            m_readdatavalid = (k >= 4);
            m_readdata = 16'h0100 + 16'(k);
            #1;
            if (k >= 4) begin
                check($sformatf("ilv_rdv0_%0d", k), s0_readdatavalid, (ip[k-4] == 0) ? 1 : 0);
                check($sformatf("ilv_rdv1_%0d", k), s1_readdatavalid, (ip[k-4] == 1) ? 1 : 0);
            end
        end
        cyc(); idle();

        // Reset mid-operation: two reads pending and port 0 locked
        cyc(); s0_read = 1; s0_address = 24'h600;
        cyc(); s0_read = 0; s1_read = 1; s1_address = 24'h700;
        cyc(); s1_read = 0; s0_write = 1; s0_address = 24'h800; m_waitrequest = 1;
        cyc(); reset = 1;
        #1;
        check("mid_rst_wait0", s0_waitrequest, 1);
        check("mid_rst_m_write", m_write, 0);
        cyc(); reset = 0; s0_write = 0; m_waitrequest = 0; s1_write = 1; s1_address = 24'h900;
        #1;
        check("mid_nolock", s1_waitrequest, 0);
        check("mid_err_clr", err_orphan, 0);
        cyc(); s1_write = 0; m_readdatavalid = 1; m_readdata = 16'hDEAD;
        #1;
        check("late_rdv0_a", s0_readdatavalid, 0);
        check("late_rdv1_a", s1_readdatavalid, 0);
        cyc(); m_readdata = 16'hBEEF;
        #1;
        check("late_rdv0_b", s0_readdatavalid, 0);
        check("late_rdv1_b", s1_readdatavalid, 0);
        check("late_err_a", err_orphan, 1);
        cyc(); idle();
        #1 check("late_err_b", err_orphan, 1);

        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
